// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch core: start/stop toggles run/pause, clear returns to 00:00 idle.
// A prescaler of TICK_DIV clocks drives a four-digit BCD counter that rolls over at 59:59.
module bcd_stopwatch #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_u_q, sec_u_d;
    logic [3:0]    sec_t_q, sec_t_d;
    logic [3:0]    min_u_q, min_u_d;
    logic [3:0]    min_t_q, min_t_d;
    logic          running_q, running_d;
    logic          wrap_q, wrap_d;
    logic          ss_prev_q, ss_prev_d;
    logic          ss_rise;
    logic          step;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        sec_u_d   = sec_u_q;
        sec_t_d   = sec_t_q;
        min_u_d   = min_u_q;
        min_t_d   = min_t_q;
        wrap_d    = 1'b0;
        step      = 1'b0;
        ss_rise   = start_stop & ~ss_prev_q;
        ss_prev_d = start_stop;

        case (state_q)
            IDLE:    if (ss_rise) state_d = RUN;
            RUN:     if (ss_rise) state_d = PAUSE;
            PAUSE:   if (ss_rise) state_d = RUN;
            default: state_d = IDLE;
        endcase

        // Prescaler only advances in RUN, so a pause resumes mid-interval.
        if (state_q == RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (step) begin
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                if (sec_t_q == 4'd5) begin
                    sec_t_d = 4'd0;
                    if (min_u_q == 4'd9) begin
                        min_u_d = 4'd0;
                        if (min_t_q == 4'd5) begin
                            min_t_d = 4'd0;
                            wrap_d  = 1'b1;
                        end else begin
                            min_t_d = min_t_q + 4'd1;
                        end
                    end else begin
                        min_u_d = min_u_q + 4'd1;
                    end
                end else begin
                    sec_t_d = sec_t_q + 4'd1;
                end
            end else begin
                sec_u_d = sec_u_q + 4'd1;
            end
        end

        // Clear overrides both a pending step and a start edge.
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            sec_u_d = 4'd0;
            sec_t_d = 4'd0;
            min_u_d = 4'd0;
            min_t_d = 4'd0;
            wrap_d  = 1'b0;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            sec_u_q   <= 4'd0;
            sec_t_q   <= 4'd0;
            min_u_q   <= 4'd0;
            min_t_q   <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            ss_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_u_q   <= sec_u_d;
            sec_t_q   <= sec_t_d;
            min_u_q   <= min_u_d;
            min_t_q   <= min_t_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            ss_prev_q <= ss_prev_d;
        end
    end

    assign sec_u   = sec_u_q;
    assign sec_t   = sec_t_q;
    assign min_u   = min_u_q;
    assign min_t   = min_t_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: vector table, corner-case sequences and random stimulus,
// all checked against a seconds-count reference model.
module tb_bcd_stopwatch;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_u, sec_t, min_u, min_t;
    logic       running, wrap;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    bcd_stopwatch #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
        .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed seconds as one integer, run flag toggled by button edges.
    int m_secs, m_presc;
    bit m_run, m_wrap, m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_secs = 0; m_presc = 0; m_run = 0; m_wrap = 0; m_prev = 1;
        end else begin
            bit rise;
            rise   = start_stop && !m_prev;
            m_prev = start_stop;
            m_wrap = 0;
            if (clear) begin
                m_secs = 0; m_presc = 0; m_run = 0;
            end else begin
                if (m_run) begin
                    if (m_presc == TD - 1) begin
                        m_presc = 0;
                        m_secs  = (m_secs + 1) % 3600;
                        m_wrap  = (m_secs == 0);
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
                if (rise) m_run = !m_run;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got digits=%h run=%b wrap=%b, want digits=%h run=%b wrap=%b",
                     name, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [17:0] dut_out();
        return {min_t, min_u, sec_t, sec_u, running, wrap};
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n)
            check("model", dut_out(), {to_bcd(m_secs), m_run, m_wrap});
    end

    task automatic cyc(input logic ss, input logic clr, input int n);
        for (int k = 0; k < n; k++) begin
            start_stop = ss;
            clear      = clr;
            @(negedge clk);
        end
    endtask

    // Advance until the model sits just before a step into second `target`+1.
    task automatic wait_secs(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (!(m_secs == target && m_presc == TD - 1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout after %0d cycles, at %0d s want %0d s", name, k, m_secs, target);
        end
    endtask

    typedef struct {
        logic ss;
        logic clr;
        int   ncyc;
        int   secs;
        logic run;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1,  0,  1'b1};  // start edge: running next cycle
        tbl[1]  = '{1'b0, 1'b0, 3,  0,  1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1,  1,  1'b1};  // first step TD cycles after start
        tbl[3]  = '{1'b0, 1'b0, 36, 10, 1'b1};  // 00:10 after 40 cycles
        tbl[4]  = '{1'b0, 1'b0, 2,  10, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1,  10, 1'b0};  // pause with prescaler at 3
        tbl[6]  = '{1'b0, 1'b0, 20, 10, 1'b0};  // frozen
        tbl[7]  = '{1'b1, 1'b0, 1,  10, 1'b1};  // resume
        tbl[8]  = '{1'b0, 1'b0, 1,  11, 1'b1};  // remaining count was 1 cycle
        tbl[9]  = '{1'b0, 1'b0, 3,  11, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1,  12, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1,  0,  1'b0};  // clear beats start edge
        tbl[12] = '{1'b0, 1'b0, 5,  0,  1'b0};
        tbl[13] = '{1'b1, 1'b0, 1,  0,  1'b1};
        tbl[14] = '{1'b0, 1'b0, 4,  1,  1'b1};

        repeat (3) @(negedge clk);
        check("reset", dut_out(), 18'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", dut_out(), 18'd0);
        chk_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].ss, tbl[i].clr, tbl[i].ncyc);
            check($sformatf("vec%0d", i), dut_out(), {to_bcd(tbl[i].secs), tbl[i].run, 1'b0});
        end

        // Carry chains and rollover from a fresh start.
        cyc(1'b0, 1'b1, 1);
        cyc(1'b1, 1'b0, 1);
        cyc(1'b0, 1'b0, 1);
        wait_secs("to_00_59", 59, 400);
        check("at_00_59", dut_out(), {16'h0059, 2'b10});
        @(negedge clk);
        check("carry_01_00", dut_out(), {16'h0100, 2'b10});
        wait_secs("to_09_59", 599, 3000);
        check("at_09_59", dut_out(), {16'h0959, 2'b10});
        @(negedge clk);
        check("carry_10_00", dut_out(), {16'h1000, 2'b10});
        wait_secs("to_59_58", 3598, 13000);
        check("at_59_58", dut_out(), {16'h5958, 2'b10});
        @(negedge clk);
        check("step_59_59", dut_out(), {16'h5959, 2'b10});
        wait_secs("to_59_59", 3599, 10);
        @(negedge clk);
        check("rollover", dut_out(), {16'h0000, 2'b11});
        @(negedge clk);
        check("wrap_one_cycle", dut_out(), {16'h0000, 2'b10});

        // Clear and start edge together while running at 12:34.
        wait_secs("to_12_34", 754, 4000);
        @(negedge clk);
        cyc(1'b1, 1'b1, 1);
        check("clear_prio", dut_out(), 18'd0);
        cyc(1'b0, 1'b0, 3);
        cyc(1'b1, 1'b0, 1);
        check("restart", dut_out(), {16'h0000, 2'b10});
        cyc(1'b0, 1'b0, 4);
        check("restart_step", dut_out(), {16'h0001, 2'b10});

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) start_stop = ~start_stop;
            clear = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end

        // Button held through reset release must not start.
        chk_en = 1'b0;
        start_stop = 1'b1;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 10);
        check("held_no_start", dut_out(), 18'd0);
        cyc(1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 1);
        cyc(1'b0, 1'b0, 10);
        check("running_before_reset", dut_out(), {16'h0002, 2'b10});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), 18'd0);
        chk_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
